// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one shared 64-bit shifter (SLL/SRL/SRA plus W variants).
// The result is registered into a single-entry buffer that can drain and reload in the same cycle.
module shift_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid0,
    input  logic [DATA_WIDTH-1:0] in_numA0,
    input  logic [DATA_WIDTH-1:0] in_numB0,
    input  logic [1:0]            in_op0,
    input  logic                  in_word0,
    output logic                  out_ready0,
    input  logic                  in_valid1,
    input  logic [DATA_WIDTH-1:0] in_numA1,
    input  logic [DATA_WIDTH-1:0] in_numB1,
    input  logic [1:0]            in_op1,
    input  logic                  in_word1,
    output logic                  out_ready1,
    output logic                  out_rsp_valid,
    output logic                  out_rsp_id,
    output logic [DATA_WIDTH-1:0] out_result,
    input  logic                  in_rsp_ready
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic                  rr_reg, rr_next;        // 1: req1 wins the next tie
    logic                  id_reg, id_next;
    logic [DATA_WIDTH-1:0] result_reg, result_next;
    logic                  can_accept, grant0, grant1;

    logic [DATA_WIDTH-1:0] req_a     [2];
    logic [DATA_WIDTH-1:0] req_b     [2];
    logic [1:0]            req_op    [2];
    logic                  req_word  [2];
    logic [DATA_WIDTH-1:0] shift_res [2];

    assign req_a[0]    = in_numA0;
    assign req_b[0]    = in_numB0;
    assign req_op[0]   = in_op0;
    assign req_word[0] = in_word0;
    assign req_a[1]    = in_numA1;
    assign req_b[1]    = in_numB1;
    assign req_op[1]   = in_op1;
    assign req_word[1] = in_word1;

    // Both requesters get their own shift datapath so the mux sits after the shifter.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_shift
            logic [SH_W-1:0]       sh;
            logic [31:0]           a32;
            logic [31:0]           w_res;
            logic [DATA_WIDTH-1:0] d_res;

            always_comb begin
                sh    = req_word[gi] ? {1'b0, req_b[gi][4:0]} : req_b[gi][SH_W-1:0];
                a32   = req_a[gi][31:0];
                w_res = '0;
                d_res = '0;
                case (req_op[gi])
                    2'b00: begin
                        d_res = req_a[gi] << sh;
                        w_res = a32 << sh[4:0];
                    end
                    2'b01: begin
                        d_res = req_a[gi] >> sh;
                        w_res = a32 >> sh[4:0];
                    end
                    2'b10: begin
                        d_res = $unsigned($signed(req_a[gi]) >>> sh);
                        w_res = $unsigned($signed(a32) >>> sh[4:0]);
                    end
                    default: ;
                endcase
                if (req_op[gi] == 2'b11) begin
                    shift_res[gi] = '0;
                end else if (req_word[gi]) begin
                    shift_res[gi] = {{(DATA_WIDTH-32){w_res[31]}}, w_res};
                end else begin
                    shift_res[gi] = d_res;
                end
            end
        end
    endgenerate

    always_comb begin
        can_accept  = (state_reg == EMPTY) || (in_rsp_ready && (state_reg == FULL));
        grant0      = 1'b0;
        grant1      = 1'b0;
        state_next  = state_reg;
        rr_next     = rr_reg;
        id_next     = id_reg;
        result_next = result_reg;

        // Readies are forced low while reset is held so nothing handshakes into a clearing buffer.
        if (can_accept && !in_rst) begin
            if (in_valid0 && in_valid1) begin
                grant0 = ~rr_reg;
                grant1 = rr_reg;
            end else begin
                grant0 = in_valid0;
                grant1 = in_valid1;
            end
        end

        if (grant0 || grant1) begin
            state_next  = FULL;
            rr_next     = grant0;
            id_next     = grant1;
            result_next = grant1 ? shift_res[1] : shift_res[0];
        end else if (in_rsp_ready && (state_reg == FULL)) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_reg  <= EMPTY;
            rr_reg     <= 1'b0;
            id_reg     <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_reg     <= rr_next;
            id_reg     <= id_next;
            result_reg <= result_next;
        end
    end

    assign out_ready0    = grant0;
    assign out_ready1    = grant1;
    assign out_rsp_valid = (state_reg == FULL);
    assign out_rsp_id    = id_reg;
    assign out_result    = result_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: per-scenario tasks with inline checks, and a
// scoreboard queue that is filled on each accepted request and drained on each consumed result.
module tb_shift_arbiter;
    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_valid0, in_valid1;
    logic [63:0] in_numA0, in_numB0, in_numA1, in_numB1;
    logic [1:0]  in_op0, in_op1;
    logic        in_word0, in_word1;
    logic        out_ready0, out_ready1;
    logic        out_rsp_valid, out_rsp_id;
    logic [63:0] out_result;
    logic        in_rsp_ready;

    int total = 0;
    int bad   = 0;
    logic [64:0] sb_q[$];

    always #5 in_clk = ~in_clk;

    shift_arbiter #(.DATA_WIDTH(64)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_valid0(in_valid0), .in_numA0(in_numA0), .in_numB0(in_numB0),
        .in_op0(in_op0), .in_word0(in_word0), .out_ready0(out_ready0),
        .in_valid1(in_valid1), .in_numA1(in_numA1), .in_numB1(in_numB1),
        .in_op1(in_op1), .in_word1(in_word1), .out_ready1(out_ready1),
        .out_rsp_valid(out_rsp_valid), .out_rsp_id(out_rsp_id),
        .out_result(out_result), .in_rsp_ready(in_rsp_ready)
    );

    // Bit-by-bit reference shifter.
    function automatic logic [63:0] ref_shift(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] op, input logic word);
        int n, sh;
        logic [63:0] r;
        r  = '0;
        n  = word ? 32 : 64;
        sh = word ? int'(b[4:0]) : int'(b[5:0]);
        if (op == 2'b11) return 64'h0;
        for (int i = 0; i < n; i++) begin
            if (op == 2'b00) r[i] = (i >= sh) ? a[i - sh] : 1'b0;
            else if (op == 2'b01) r[i] = (i + sh < n) ? a[i + sh] : 1'b0;
            else r[i] = (i + sh < n) ? a[i + sh] : a[n - 1];
        end
        if (word) for (int i = 32; i < 64; i++) r[i] = r[31];
        return r;
    endfunction

    // Scoreboard: pop on consumed result, push on accepted request.
    always @(negedge in_clk) begin
        if (!in_rst) begin
            if (out_rsp_valid && in_rsp_ready) begin
                logic [64:0] exp_e;
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got id=%0d res=%h want no result", out_rsp_id, out_result);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({out_rsp_id, out_result} !== exp_e) begin
                        bad++;
                        $display("FAIL sb_result: got id=%0d res=%h want id=%0d res=%h",
                                 out_rsp_id, out_result, exp_e[64], exp_e[63:0]);
                    end else begin
                        $display("rsp id=%0d res=%h ok", out_rsp_id, out_result);
                    end
                end
            end
            if (out_ready0 && in_valid0) sb_q.push_back({1'b0, ref_shift(in_numA0, in_numB0, in_op0, in_word0)});
            if (out_ready1 && in_valid1) sb_q.push_back({1'b1, ref_shift(in_numA1, in_numB1, in_op1, in_word1)});
        end
    end

    task automatic next_cycle();
        @(posedge in_clk);
        #1;
    endtask

    task automatic set_req(input int side, input logic v, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] op, input logic w);
        if (side == 0) begin
            in_valid0 = v; in_numA0 = a; in_numB0 = b; in_op0 = op; in_word0 = w;
        end else begin
            in_valid1 = v; in_numA1 = a; in_numB1 = b; in_op1 = op; in_word1 = w;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            in_valid0 = 1'b0;
            in_valid1 = 1'b0;
            in_rsp_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) next_cycle();
        #3;
        total++;
        if ({out_rsp_valid, out_rsp_id, out_ready0, out_ready1} !== 4'b0000 || out_result !== 64'h0) begin
            bad++;
            $display("FAIL reset_state: got v=%b id=%b r0=%b r1=%b res=%h want all 0",
                     out_rsp_valid, out_rsp_id, out_ready0, out_ready1, out_result);
        end
        next_cycle();
        in_rst = 1'b0;
        set_req(0, 1, 64'h1234, 64'd4, 2'b00, 1'b0);
        set_req(1, 0, 64'h0, 64'h0, 2'b00, 1'b0);
        #3;
        total++;
        if (out_ready0 !== 1'b1) begin bad++; $display("FAIL reset_first_grant: got %b want 1", out_ready0); end
        next_cycle();
        in_valid0 = 1'b0;
        #3;
        total++;
        if (out_rsp_valid !== 1'b1) begin bad++; $display("FAIL reset_fill: got %b want 1", out_rsp_valid); end
        next_cycle();
        in_rst = 1'b1;
        sb_q.delete();
        set_req(0, 1, 64'h55, 64'd1, 2'b00, 1'b0);
        set_req(1, 1, 64'h66, 64'd2, 2'b01, 1'b0);
        #3;
        total++;
        if ({out_rsp_valid, out_ready0, out_ready1} !== 3'b000) begin
            bad++;
            $display("FAIL reset_midfull: got v=%b r0=%b r1=%b want 000", out_rsp_valid, out_ready0, out_ready1);
        end
        next_cycle();
        in_rst = 1'b0;
        in_rsp_ready = 1'b1;
        #3;
        total++;
        if ({out_ready0, out_ready1} !== 2'b10) begin
            bad++;
            $display("FAIL reset_rr: got r0=%b r1=%b want 10", out_ready0, out_ready1);
        end
        next_cycle();
        #3;
        total++;
        if ({out_ready0, out_ready1, out_rsp_valid, out_rsp_id} !== 4'b0110) begin
            bad++;
            $display("FAIL reset_second: got r0=%b r1=%b v=%b id=%b want 0110",
                     out_ready0, out_ready1, out_rsp_valid, out_rsp_id);
        end
        idle(2);
    endtask

    task automatic test_arith();
        next_cycle();
        set_req(0, 1, 64'h8000_0000_0000_0000, 64'd63, 2'b10, 1'b0);
        #3;
        total++;
        if (out_ready0 !== 1'b1) begin bad++; $display("FAIL arith_grant: got %b want 1", out_ready0); end
        next_cycle();
        set_req(0, 1, 64'h8000_0000_0000_0000, 64'd63, 2'b01, 1'b0);
        #3;
        total++;
        if (out_rsp_valid !== 1'b1 || out_rsp_id !== 1'b0 || out_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL arith_sra: got v=%b id=%b res=%h want 1 0 ffffffffffffffff", out_rsp_valid, out_rsp_id, out_result);
        end
        next_cycle();
        in_valid0 = 1'b0;
        #3;
        total++;
        if (out_result !== 64'h1 || out_rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL arith_srl: got id=%b res=%h want 0 1", out_rsp_id, out_result);
        end
        idle(2);
    endtask

    task automatic test_word();
        logic [63:0] exp_r [3];
        logic [1:0]  ops   [3];
        exp_r[0] = 64'h0000_0000_4000_0000; ops[0] = 2'b01;
        exp_r[1] = 64'hFFFF_FFFF_C000_0000; ops[1] = 2'b10;
        exp_r[2] = 64'h0000_0000_0000_0002; ops[2] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i < 3) set_req(1, 1, 64'hFFFF_FFFF_8000_0001, 64'h41, ops[i], 1'b1);
            else in_valid1 = 1'b0;
            #3;
            if (i > 0) begin
                total++;
                if (out_rsp_valid !== 1'b1 || out_rsp_id !== 1'b1 || out_result !== exp_r[i-1]) begin
                    bad++;
                    $display("FAIL word_op%0d: got v=%b id=%b res=%h want 1 1 %h",
                             i - 1, out_rsp_valid, out_rsp_id, out_result, exp_r[i-1]);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_round_robin();
        logic exp_g;
        logic [63:0] a [2];
        logic [63:0] b [2];
        logic [1:0]  op [2];
        logic        w [2];
        for (int s = 0; s < 2; s++) begin
            a[s] = {$urandom, $urandom}; b[s] = 64'($urandom); op[s] = 2'($urandom_range(0, 3)); w[s] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            set_req(0, 1, a[0], b[0], op[0], w[0]);
            set_req(1, 1, a[1], b[1], op[1], w[1]);
            exp_g = 1'(i % 2);
            #3;
            total++;
            if (out_ready0 !== ~exp_g || out_ready1 !== exp_g) begin
                bad++;
                $display("FAIL rr_grant%0d: got r0=%b r1=%b want grant to %0d", i, out_ready0, out_ready1, exp_g);
            end
            if (i > 0) begin
                total++;
                if (out_rsp_valid !== 1'b1 || out_rsp_id !== ~exp_g) begin
                    bad++;
                    $display("FAIL rr_rsp%0d: got v=%b id=%b want 1 %0d", i, out_rsp_valid, out_rsp_id, ~exp_g);
                end
            end
            a[exp_g] = {$urandom, $urandom}; b[exp_g] = 64'($urandom);
            op[exp_g] = 2'($urandom_range(0, 3)); w[exp_g] = 1'($urandom_range(0, 1));
        end
        next_cycle();
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        #3;
        total++;
        if (out_rsp_valid !== 1'b1 || out_rsp_id !== 1'b1) begin
            bad++;
            $display("FAIL rr_last: got v=%b id=%b want 1 1", out_rsp_valid, out_rsp_id);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        logic [63:0] exp0, exp1;
        exp0 = 64'h1234_5678_9ABC_DEF0;
        exp1 = 64'hFFF0_0000_0000_0000;
        next_cycle();
        set_req(0, 1, 64'h0123_4567_89AB_CDEF, 64'd4, 2'b00, 1'b0);
        #3;
        total++;
        if (out_ready0 !== 1'b1) begin bad++; $display("FAIL bp_grant: got %b want 1", out_ready0); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            in_rsp_ready = 1'b0;
            in_valid0 = 1'b0;
            set_req(1, 1, 64'hF000_0000_0000_0000, 64'd8, 2'b10, 1'b0);
            #3;
            total++;
            if ({out_ready0, out_ready1, out_rsp_valid, out_rsp_id} !== 4'b0010 || out_result !== exp0) begin
                bad++;
                $display("FAIL bp_hold%0d: got r0=%b r1=%b v=%b id=%b res=%h want 0 0 1 0 %h",
                         i, out_ready0, out_ready1, out_rsp_valid, out_rsp_id, out_result, exp0);
            end
        end
        next_cycle();
        in_rsp_ready = 1'b1;
        #3;
        total++;
        if (out_ready1 !== 1'b1 || out_rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain_grant: got r1=%b v=%b want 1 1", out_ready1, out_rsp_valid);
        end
        next_cycle();
        in_valid1 = 1'b0;
        #3;
        total++;
        if (out_rsp_valid !== 1'b1 || out_rsp_id !== 1'b1 || out_result !== exp1) begin
            bad++;
            $display("FAIL bp_next: got v=%b id=%b res=%h want 1 1 %h", out_rsp_valid, out_rsp_id, out_result, exp1);
        end
        idle(2);
    endtask

    task automatic test_boundary();
        logic [63:0] a;
        logic [63:0] bs  [4];
        logic [1:0]  ops [4];
        logic        ws  [4];
        logic [63:0] exp_r [4];
        a = 64'hDEAD_BEEF_8765_4321;
        bs[0] = 64'd64; ops[0] = 2'b00; ws[0] = 1'b0; exp_r[0] = a;
        bs[1] = 64'd64; ops[1] = 2'b10; ws[1] = 1'b0; exp_r[1] = a;
        bs[2] = 64'd5;  ops[2] = 2'b11; ws[2] = 1'b0; exp_r[2] = 64'h0;
        bs[3] = 64'd32; ops[3] = 2'b01; ws[3] = 1'b1; exp_r[3] = 64'hFFFF_FFFF_8765_4321;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i < 4) set_req(0, 1, a, bs[i], ops[i], ws[i]);
            else in_valid0 = 1'b0;
            #3;
            if (i > 0) begin
                total++;
                if (out_rsp_valid !== 1'b1 || out_result !== exp_r[i-1]) begin
                    bad++;
                    $display("FAIL boundary%0d: got v=%b res=%h want 1 %h", i - 1, out_rsp_valid, out_result, exp_r[i-1]);
                end
            end
        end
        idle(2);
    endtask

    initial begin
        in_rst = 1'b1;
        in_rsp_ready = 1'b0;
        set_req(0, 1, 64'h0, 64'h0, 2'b00, 1'b0);
        set_req(1, 1, 64'h0, 64'h0, 2'b00, 1'b0);
        test_reset();
        test_arith();
        test_word();
        test_round_robin();
        test_backpressure();
        test_boundary();
        idle(3);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending results want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
